// File: rtl/avgpool_if.sv
// -----------------------------------------------------------------------------
// avgpool_if -- channel-beat input and averaged-vector output of avgpool_top.
//
// Signals
//   pool_valid_i  : one channel beat present on pool_pixel_i
//   pool_pixel_i  : PIXEL_NUM signed pixels, pixel p at [p*DATA_W +: DATA_W]
//   pool_clr_i    : synchronous frame restart
//   pool_vec_o    : averaged vector, channel k at [k*DATA_W +: DATA_W]
//   pool_valid_o  : one-cycle pulse marking a new complete pool_vec_o
//   pool_busy_o   : a frame is being collected or a beat is still in flight
//
// Modports
//   master : the beat producer / vector consumer
//   slave  : the pooling block
// -----------------------------------------------------------------------------
interface avgpool_if #(
   parameter int DATA_W    = 8,
   parameter int PIXEL_NUM = 36,
   parameter int CH_NUM    = 32
);
   logic                          pool_valid_i;
   logic [PIXEL_NUM*DATA_W-1:0]   pool_pixel_i;
   logic                          pool_clr_i;
   logic [CH_NUM*DATA_W-1:0]      pool_vec_o;
   logic                          pool_valid_o;
   logic                          pool_busy_o;

   modport master (
      output pool_valid_i,
      output pool_pixel_i,
      output pool_clr_i,
      input  pool_vec_o,
      input  pool_valid_o,
      input  pool_busy_o
   );

   modport slave (
      input  pool_valid_i,
      input  pool_pixel_i,
      input  pool_clr_i,
      output pool_vec_o,
      output pool_valid_o,
      output pool_busy_o
   );
endinterface

// File: rtl/avgpool_top.sv
// -----------------------------------------------------------------------------
// avgpool_top -- global average pooling over an 18 x 2 feature map.
//
// Each accepted beat carries every pixel of one channel. The beat is reduced
// to the rounded mean of its PIXEL_NUM pixels and stored in the next slot of a
// working buffer; once CH_NUM channels are stored the whole buffer is
// published on pool_vec_o with a single-cycle pool_valid_o pulse.
//
// Pipeline (edge E0 samples a beat):
//   E0 : stage 1 registers the pixel sum S
//   E1 : stage 2 registers A = sat(((S*1821) + 32768) >>> 16)   (1821/65536 ~ 1/36)
//   E2 : stage 3 writes A into slot ch_cnt; the last slot moves the FSM to EMIT
//   E3 : EMIT copies the buffer to pool_vec_o and raises pool_valid_o
// so pool_valid_o rises on the fourth edge counting the one that sampled the
// final beat. A beat for the next frame may write slot 0 on E3 itself; the
// copy reads the buffer before that write lands.
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : avgpool_if.slave (pool_valid_i, pool_pixel_i, pool_clr_i,
//           pool_vec_o, pool_valid_o, pool_busy_o)
//
// Configuration
//   AVGPOOL_RELU_EN : when defined, negative pixels are clamped to zero before
//                     summation.
// -----------------------------------------------------------------------------
module avgpool_top #(
   parameter int DATA_W    = 8,
   parameter int PIXEL_NUM = 36,
   parameter int CH_NUM    = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   avgpool_if.slave  bus
);

   localparam int SUM_W  = DATA_W + 6;
   localparam int PROD_W = SUM_W + 12;
   localparam int CNT_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   localparam logic signed [PROD_W-1:0] RECIP_C   = PROD_W'(1821);
   localparam logic signed [PROD_W-1:0] ROUND_C   = PROD_W'(32768);
   localparam logic signed [PROD_W-1:0] SAT_MAX_C = PROD_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [PROD_W-1:0] SAT_MIN_C = PROD_W'(-(1 << (DATA_W - 1)));
   localparam logic [CNT_W-1:0]         LAST_CH_C = CNT_W'(CH_NUM - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } state_t;

   // stage 1
   logic signed [DATA_W-1:0]   pix_s;
   logic signed [SUM_W-1:0]    sum_s;
   logic                       s1_vld_r;
   logic signed [SUM_W-1:0]    s1_sum_r;

   // stage 2
   logic signed [PROD_W-1:0]   prod_s;
   logic signed [PROD_W-1:0]   scaled_s;
   logic signed [DATA_W-1:0]   avg_s;
   logic                       s2_vld_r;
   logic signed [DATA_W-1:0]   s2_avg_r;

   // stage 3 / working buffer
   logic [DATA_W-1:0]          buf_r [CH_NUM];
   logic [CH_NUM*DATA_W-1:0]   buf_flat_s;
   logic [CNT_W-1:0]           ch_cnt_r;
   logic                       wr_s;
   logic                       last_s;

   // control and outputs
   state_t                     state_r;
   state_t                     state_nxt_s;
   logic                       busy_nxt_s;
   logic [CH_NUM*DATA_W-1:0]   vec_r;
   logic                       valid_r;
   logic                       busy_r;

   // Sum all pixels of the incoming beat, sign-extended to the stage-1 width.
   always_comb begin
      sum_s = '0;
      pix_s = '0;
      for (int p = 0; p < PIXEL_NUM; p++) begin
         pix_s = bus.pool_pixel_i[p*DATA_W +: DATA_W];
`ifdef AVGPOOL_RELU_EN
         pix_s = pix_s[DATA_W-1] ? '0 : pix_s;
`endif
         sum_s = sum_s + $signed({{(SUM_W - DATA_W){pix_s[DATA_W-1]}}, pix_s});
      end
   end

   // Scale the sum by 1/36 with round-half-up and saturate to the pixel range.
   always_comb begin
      prod_s   = PROD_W'(s1_sum_r) * RECIP_C;
      scaled_s = (prod_s + ROUND_C) >>> 5'd16;
      if (scaled_s > SAT_MAX_C) begin
         avg_s = SAT_MAX_C[DATA_W-1:0];
      end else if (scaled_s < SAT_MIN_C) begin
         avg_s = SAT_MIN_C[DATA_W-1:0];
      end else begin
         avg_s = scaled_s[DATA_W-1:0];
      end
   end

   // Flatten the working buffer into the output vector layout.
   always_comb begin
      buf_flat_s = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         buf_flat_s[k*DATA_W +: DATA_W] = buf_r[k];
      end
   end

   // Stage-3 write strobe and next state; a clear overrides any write.
   always_comb begin
      wr_s        = s2_vld_r & ~bus.pool_clr_i;
      last_s      = wr_s && (ch_cnt_r == LAST_CH_C);
      state_nxt_s = state_r;
      if (bus.pool_clr_i) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (wr_s) begin
                  state_nxt_s = last_s ? ST_EMIT : ST_COLLECT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_COLLECT: begin
               if (last_s) begin
                  state_nxt_s = ST_EMIT;
               end else begin
                  state_nxt_s = ST_COLLECT;
               end
            end
            ST_EMIT: begin
               if (wr_s) begin
                  state_nxt_s = last_s ? ST_EMIT : ST_COLLECT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
      // Busy mirrors the state and the stage valids as they will be after this edge.
      busy_nxt_s = (state_nxt_s != ST_IDLE) || bus.pool_valid_i ||
                   (s1_vld_r && !bus.pool_clr_i);
   end

   // Stages 1 and 2; a clear drops the beat in stage 1 but still accepts a new one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_r <= 1'b0;
         s1_sum_r <= '0;
         s2_vld_r <= 1'b0;
         s2_avg_r <= '0;
      end else begin
         s1_vld_r <= bus.pool_valid_i;
         if (bus.pool_valid_i) begin
            s1_sum_r <= sum_s;
         end
         s2_vld_r <= s1_vld_r & ~bus.pool_clr_i;
         if (s1_vld_r) begin
            s2_avg_r <= avg_s;
         end
      end
   end

   // Stage 3: working buffer and channel counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CH_NUM; k++) begin
            buf_r[k] <= '0;
         end
         ch_cnt_r <= '0;
      end else if (bus.pool_clr_i) begin
         for (int k = 0; k < CH_NUM; k++) begin
            buf_r[k] <= '0;
         end
         ch_cnt_r <= '0;
      end else if (wr_s) begin
         buf_r[ch_cnt_r] <= s2_avg_r;
         ch_cnt_r        <= last_s ? '0 : ch_cnt_r + CNT_W'(1);
      end
   end

   // Frame FSM with registered vector, pulse and busy outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         vec_r   <= '0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= busy_nxt_s;
         if (bus.pool_clr_i) begin
            valid_r <= 1'b0;
         end else if (state_r == ST_EMIT) begin
            vec_r   <= buf_flat_s;
            valid_r <= 1'b1;
         end else begin
            valid_r <= 1'b0;
         end
      end
   end

   assign bus.pool_vec_o   = vec_r;
   assign bus.pool_valid_o = valid_r;
   assign bus.pool_busy_o  = busy_r;

endmodule

// File: tb/tb_avgpool_top.sv
// -----------------------------------------------------------------------------
// tb_avgpool_top -- self-checking bench for avgpool_top.
// Beats are driven on the falling edge; a falling-edge monitor records every
// pool_valid_o pulse (vector and edge number). A reference model computes the
// expected vectors from the pixel values with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_avgpool_top;

   localparam int DATA_W    = 8;
   localparam int PIXEL_NUM = 36;
   localparam int CH_NUM    = 32;
   localparam int PW        = PIXEL_NUM * DATA_W;
   localparam int VW        = CH_NUM * DATA_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   avgpool_if #(.DATA_W(DATA_W), .PIXEL_NUM(PIXEL_NUM), .CH_NUM(CH_NUM)) bus ();

   avgpool_top #(.DATA_W(DATA_W), .PIXEL_NUM(PIXEL_NUM), .CH_NUM(CH_NUM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int last_edge = 0;

   logic [VW-1:0] got_vec [$];
   int            got_edge[$];
   logic [VW-1:0] exp_vec [$];
   int            frame_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.pool_valid_o === 1'b1) begin
         got_vec.push_back(bus.pool_vec_o);
         got_edge.push_back(cyc);
      end
   end

   // Rounded mean of one channel, straight from the pooling rule.
   function automatic int ref_avg(input logic [PW-1:0] px);
      int s, v, num, q;
      s = 0;
      for (int p = 0; p < PIXEL_NUM; p++) begin
         v = int'($signed(px[p*DATA_W +: DATA_W]));
`ifdef AVGPOOL_RELU_EN
         if (v < 0) v = 0;
`endif
         s += v;
      end
      num = s * 1821 + 32768;
      q = num / 65536;
      if (num < 0 && (q * 65536) != num) q = q - 1;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   function automatic logic [PW-1:0] fill_px(input int v);
      logic [PW-1:0] px;
      for (int p = 0; p < PIXEL_NUM; p++) px[p*DATA_W +: DATA_W] = DATA_W'(v);
      return px;
   endfunction

   function automatic logic [PW-1:0] rand_px();
      logic [PW-1:0] px;
      for (int p = 0; p < PIXEL_NUM; p++) px[p*DATA_W +: DATA_W] = DATA_W'($urandom);
      return px;
   endfunction

   function automatic logic [VW-1:0] const_vec(input int v);
      logic [VW-1:0] vv;
      for (int k = 0; k < CH_NUM; k++) vv[k*DATA_W +: DATA_W] = DATA_W'(v);
      return vv;
   endfunction

   task automatic model_beat(input logic [PW-1:0] px);
      logic [VW-1:0] vv;
      frame_q.push_back(ref_avg(px));
      if (frame_q.size() == CH_NUM) begin
         for (int k = 0; k < CH_NUM; k++) vv[k*DATA_W +: DATA_W] = DATA_W'(frame_q[k]);
         exp_vec.push_back(vv);
         frame_q.delete();
      end
   endtask

   task automatic beat(input logic [PW-1:0] px, input logic clr);
      @(negedge clk);
      bus.pool_valid_i = 1'b1;
      bus.pool_pixel_i = px;
      bus.pool_clr_i   = clr;
      if (clr) frame_q.delete();
      model_beat(px);
      @(posedge clk);
      #1;
      last_edge = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.pool_valid_i = 1'b0;
         bus.pool_clr_i   = 1'b0;
      end
   endtask

   task automatic clear_only();
      @(negedge clk);
      bus.pool_valid_i = 1'b0;
      bus.pool_clr_i   = 1'b1;
      frame_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_queues();
      got_vec.delete();
      got_edge.delete();
      exp_vec.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (bus.pool_vec_o !== '0) begin errors++; $display("FAIL reset_vec: got %h want 0", bus.pool_vec_o); end
      checks++; if (bus.pool_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.pool_valid_o); end
      checks++; if (bus.pool_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.pool_busy_o); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_ramp();
      logic signed [DATA_W-1:0] sl;
      int e;
      reset_queues();
      for (int k = 0; k < CH_NUM; k++) beat(fill_px(k - 16), 1'b0);
      e = last_edge;
      idle(8);
      checks++; if (got_vec.size() !== 1) begin errors++; $display("FAIL ramp_pulses: got %0d want 1", got_vec.size()); end
      if (got_vec.size() > 0) begin
         checks++; if (got_edge[0] !== e + 3) begin errors++; $display("FAIL ramp_latency: got edge %0d want %0d", got_edge[0], e + 3); end
         for (int k = 0; k < CH_NUM; k++) begin
            sl = got_vec[0][k*DATA_W +: DATA_W];
            checks++; if (int'(sl) !== k - 16) begin errors++; $display("FAIL ramp_slot%0d: got %0d want %0d", k, sl, k - 16); end
         end
      end
      checks++; if (bus.pool_busy_o !== 1'b0) begin errors++; $display("FAIL ramp_busy_idle: got %b want 0", bus.pool_busy_o); end
   endtask

   task automatic test_saturation();
      reset_queues();
      for (int k = 0; k < CH_NUM; k++) beat(fill_px(127), 1'b0);
      idle(8);
      for (int k = 0; k < CH_NUM / 2; k++) beat(fill_px(-128), 1'b0);
      checks++; if (bus.pool_vec_o !== const_vec(127)) begin errors++; $display("FAIL sat_hold: got %h want %h", bus.pool_vec_o, const_vec(127)); end
      checks++; if (bus.pool_busy_o !== 1'b1) begin errors++; $display("FAIL sat_busy_mid: got %b want 1", bus.pool_busy_o); end
      for (int k = 0; k < CH_NUM / 2; k++) beat(fill_px(-128), 1'b0);
      idle(8);
      checks++; if (got_vec.size() !== 2) begin errors++; $display("FAIL sat_pulses: got %0d want 2", got_vec.size()); end
      if (got_vec.size() == 2) begin
         checks++; if (got_vec[0] !== const_vec(127)) begin errors++; $display("FAIL sat_pos: got %h want %h", got_vec[0], const_vec(127)); end
         checks++; if (got_vec[1] !== const_vec(-128)) begin errors++; $display("FAIL sat_neg: got %h want %h", got_vec[1], const_vec(-128)); end
      end
   endtask

   task automatic test_rounding_random();
      logic [PW-1:0] px;
      reset_queues();
      px = '0; px[$urandom_range(0, PIXEL_NUM - 1)*DATA_W +: DATA_W] = 8'sd18;
      beat(px, 1'b0);
      px = '0; px[$urandom_range(0, PIXEL_NUM - 1)*DATA_W +: DATA_W] = 8'sd17;
      beat(px, 1'b0);
      for (int k = 2; k < CH_NUM; k++) begin
         beat(rand_px(), 1'b0);
         idle($urandom_range(0, 2));
      end
      idle(8);
      checks++; if (got_vec.size() !== 1) begin errors++; $display("FAIL round_pulses: got %0d want 1", got_vec.size()); end
      if (got_vec.size() == 1 && exp_vec.size() == 1) begin
         checks++; if (got_vec[0][7:0] !== 8'd1) begin errors++; $display("FAIL round_up18: got %0d want 1", got_vec[0][7:0]); end
         checks++; if (got_vec[0][15:8] !== 8'd0) begin errors++; $display("FAIL round_down17: got %0d want 0", got_vec[0][15:8]); end
         checks++; if (got_vec[0] !== exp_vec[0]) begin errors++; $display("FAIL random_vec: got %h want %h", got_vec[0], exp_vec[0]); end
      end
   endtask

   task automatic test_clear();
      logic [VW-1:0] prev;
      reset_queues();
      for (int k = 0; k < 20; k++) beat(rand_px(), 1'b0);
      idle(3);
      clear_only();
      for (int k = 0; k < CH_NUM; k++) beat(fill_px(5), 1'b0);
      idle(8);
      checks++; if (got_vec.size() !== 1) begin errors++; $display("FAIL clr_pulses: got %0d want 1", got_vec.size()); end
      if (got_vec.size() == 1) begin
         checks++; if (got_vec[0] !== const_vec(5)) begin errors++; $display("FAIL clr_vec5: got %h want %h", got_vec[0], const_vec(5)); end
      end
      // clear together with a beat: that beat becomes channel 0
      reset_queues();
      for (int k = 0; k < 10; k++) beat(rand_px(), 1'b0);
      beat(rand_px(), 1'b1);
      for (int k = 1; k < CH_NUM; k++) beat(rand_px(), 1'b0);
      idle(8);
      checks++; if (got_vec.size() !== 1 || exp_vec.size() !== 1) begin errors++; $display("FAIL clr_beat_pulses: got %0d want 1", got_vec.size()); end
      else begin
         checks++; if (got_vec[0] !== exp_vec[0]) begin errors++; $display("FAIL clr_beat_vec: got %h want %h", got_vec[0], exp_vec[0]); end
      end
      // clear on the edge that would raise pool_valid_o suppresses the pulse
      prev = (exp_vec.size() > 0) ? exp_vec[0] : '0;
      reset_queues();
      for (int k = 0; k < CH_NUM; k++) beat(rand_px(), 1'b0);
      idle(2);
      clear_only();
      void'(exp_vec.pop_back());
      idle(8);
      checks++; if (got_vec.size() !== 0) begin errors++; $display("FAIL clr_suppress: got %0d pulses want 0", got_vec.size()); end
      checks++; if (bus.pool_vec_o !== prev) begin errors++; $display("FAIL clr_vec_hold: got %h want %h", bus.pool_vec_o, prev); end
   endtask

   task automatic test_relu();
      logic [PW-1:0] px;
      int want;
      reset_queues();
      for (int p = 0; p < PIXEL_NUM; p++) px[p*DATA_W +: DATA_W] = (p < 18) ? -8'sd100 : 8'sd100;
      beat(px, 1'b0);
      for (int k = 1; k < CH_NUM; k++) beat(rand_px(), 1'b0);
      idle(8);
`ifdef AVGPOOL_RELU_EN
      want = 50;
`else
      want = 0;
`endif
      checks++; if (got_vec.size() !== 1) begin errors++; $display("FAIL relu_pulses: got %0d want 1", got_vec.size()); end
      if (got_vec.size() == 1 && exp_vec.size() == 1) begin
         checks++; if (int'($signed(got_vec[0][7:0])) !== want) begin errors++; $display("FAIL relu_slot0: got %0d want %0d", $signed(got_vec[0][7:0]), want); end
         checks++; if (got_vec[0] !== exp_vec[0]) begin errors++; $display("FAIL relu_vec: got %h want %h", got_vec[0], exp_vec[0]); end
      end
   endtask

   task automatic test_midreset();
      reset_queues();
      for (int k = 0; k < 10; k++) beat(rand_px(), 1'b0);
      @(negedge clk);
      bus.pool_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      frame_q.delete();
      #1;
      checks++; if (bus.pool_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.pool_busy_o); end
      checks++; if (bus.pool_vec_o !== '0) begin errors++; $display("FAIL rst_vec: got %h want 0", bus.pool_vec_o); end
      @(negedge clk);
      checks++; if (bus.pool_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.pool_valid_o); end
      rst_n = 1'b1;
      for (int k = 0; k < CH_NUM; k++) beat(fill_px(3), 1'b0);
      idle(8);
      checks++; if (got_vec.size() !== 1) begin errors++; $display("FAIL rst_pulses: got %0d want 1", got_vec.size()); end
      if (got_vec.size() == 1) begin
         checks++; if (got_vec[0] !== const_vec(3)) begin errors++; $display("FAIL rst_vec3: got %h want %h", got_vec[0], const_vec(3)); end
      end
   endtask

   task automatic test_back_to_back();
      reset_queues();
      for (int k = 0; k < 3 * CH_NUM; k++) beat(rand_px(), 1'b0);
      idle(8);
      checks++; if (got_vec.size() !== 3 || exp_vec.size() !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", got_vec.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (got_vec[i] !== exp_vec[i]) begin errors++; $display("FAIL b2b_vec%0d: got %h want %h", i, got_vec[i], exp_vec[i]); end
         end
         checks++; if (got_edge[1] - got_edge[0] !== CH_NUM) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", got_edge[1] - got_edge[0], CH_NUM); end
      end
   endtask

   initial begin
      bus.pool_valid_i = 1'b0;
      bus.pool_pixel_i = '0;
      bus.pool_clr_i   = 1'b0;
      test_reset();
      test_ramp();
      test_saturation();
      test_rounding_random();
      test_clear();
      test_relu();
      test_midreset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
